i2c_target: RTL and testbench

I2C target (responder) for a 7-bit addressed bus. It recognises its own address and ACKs it. On a write it captures data bytes into a strobe interface; on a read it shifts bytes from a local data port onto SDA. It sits on the same open-drain `scl`/`sda` wires as the `i2c_top` initiator, inside the same `clk` domain, and serves as both bench responder and synthesizable peripheral front end.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_line_sync.sv | 32 +++
 rtl/i2c_target.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_target.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target front end.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_IGNORE
    } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings one bus line into the clk domain and reports its level and edges.
// Level, rise and fall are all registered together, so they are mutually
// aligned and appear 3 clk cycles after the physical transition.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;

    // Two-flop synchronizer followed by a registered edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: reset to 1 (idle, pulled-up bus) so leaving reset never
            // looks like a falling edge and fakes a START.
            sync_q <= 2'b11;
            level  <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line};
            level  <= sync_q[1];
            rise   <= sync_q[1] & ~level;
            fall   <= ~sync_q[1] & level;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: decodes its 7-bit address, captures written bytes onto a
// strobe interface and serves read bytes from rd_data. Open-drain SDA only.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'b0010000,
    parameter bit                    ACK_WRITES  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl,
    inout  wire                   sda,
    input  logic [I2C_BYTE_W-1:0] rd_data,
    output logic                  rd_strobe,
    output logic [I2C_BYTE_W-1:0] wr_data,
    output logic                  wr_valid,
    output logic                  busy,
    output logic                  addr_hit
);

    localparam logic [3:0] CNT_FULL = 4'(I2C_BYTE_W);
    localparam logic [3:0] CNT_LAST = 4'(I2C_BYTE_W - 1);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_tgt_state_e state, next_state;
    logic [3:0]            bit_cnt;
    logic [I2C_BYTE_W-1:0] shift;
    logic                  sda_low;

    // Datapath controls decoded alongside the next state.
    logic cnt_clr, cnt_inc, shift_in, shift_out, load_rd, cap_wr;
    logic hit, busy_set, busy_clr;

    i2c_line_sync u_scl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (scl),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (sda),
        .level (sda_level),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_det = sda_fall & scl_level;
    assign stop_det  = sda_rise & scl_level;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state <= next_state;
        end
    end

    // Next-state and datapath-control decode; bus conditions beat data edges.
    always_comb begin
        // NOTE: every output gets a default first, so no path infers a latch.
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        shift_in   = 1'b0;
        shift_out  = 1'b0;
        load_rd    = 1'b0;
        cap_wr     = 1'b0;
        hit        = 1'b0;
        busy_set   = 1'b0;
        busy_clr   = 1'b0;
        if (stop_det) begin
            next_state = ST_IDLE;
            busy_clr   = 1'b1;
        end else if (start_det) begin
            next_state = ST_ADDR;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_in = 1'b1;
                        cnt_inc  = 1'b1;
                    end else if (scl_fall && bit_cnt == CNT_FULL) begin
                        if (shift[I2C_BYTE_W-1:1] == TARGET_ADDR) begin
                            next_state = ST_ADDR_ACK;
                            hit        = 1'b1;
                            busy_set   = 1'b1;
                        end else begin
                            next_state = ST_IGNORE;
                            busy_clr   = 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_clr = 1'b1;
                        if (shift[0] == I2C_RW_WRITE) begin
                            next_state = ST_RX;
                        end else begin
                            next_state = ST_TX;
                            load_rd    = 1'b1;
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise) begin
                        shift_in = 1'b1;
                        cnt_inc  = 1'b1;
                        cap_wr   = (bit_cnt == CNT_LAST);
                    end else if (scl_fall && bit_cnt == CNT_FULL) begin
                        next_state = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        next_state = ST_RX;
                        cnt_clr    = 1'b1;
                    end
                end
                ST_TX: begin
                    if (scl_rise) begin
                        cnt_inc = 1'b1;
                    end else if (scl_fall) begin
                        if (bit_cnt == CNT_FULL) begin
                            next_state = ST_TX_ACK;
                        end else begin
                            shift_out = 1'b1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    // A NACK ends the read at once; an ACK reloads on the fall.
                    if (scl_rise && sda_level) begin
                        next_state = ST_IGNORE;
                        busy_clr   = 1'b1;
                    end else if (scl_fall) begin
                        next_state = ST_TX;
                        load_rd    = 1'b1;
                        cnt_clr    = 1'b1;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    // Bit counter, shifter, write capture and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift     <= '0;
            wr_data   <= '0;
            wr_valid  <= 1'b0;
            rd_strobe <= 1'b0;
            addr_hit  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_valid  <= cap_wr;
            rd_strobe <= load_rd;
            addr_hit  <= hit;
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (cnt_inc) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (load_rd) begin
                shift <= rd_data;
            end else if (shift_in) begin
                shift <= {shift[I2C_BYTE_W-2:0], sda_level};
            end else if (shift_out) begin
                shift <= {shift[I2C_BYTE_W-2:0], 1'b0};
            end
            if (cap_wr) begin
                wr_data <= {shift[I2C_BYTE_W-2:0], sda_level};
            end
            if (busy_clr) begin
                busy <= 1'b0;
            end else if (busy_set) begin
                busy <= 1'b1;
            end
        end
    end

    // SDA pull-down decode; purely from state so reset releases it at once.
    always_comb begin
        sda_low = 1'b0;
        case (state)
            ST_ADDR_ACK: sda_low = 1'b1;
            ST_RX_ACK:   sda_low = ACK_WRITES;
            ST_TX:       sda_low = ~shift[I2C_BYTE_W-1];
            default:     sda_low = 1'b0;
        endcase
    end

    assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bit-banged initiator plus a
// transaction-level model of what the target should do on the bus.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam logic [6:0] TGT  = 7'h10;
    localparam int         HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda;
    logic [7:0] rd_data;
    logic       rd_strobe, wr_valid, busy, addr_hit;
    logic [7:0] wr_data;

    logic [7:0] rd_bytes [16];
    int         rd_idx;
    assign rd_data = rd_bytes[rd_idx[3:0]];

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_target #(.TARGET_ADDR(TGT), .ACK_WRITES(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .rd_data   (rd_data),
        .rd_strobe (rd_strobe),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .busy      (busy),
        .addr_hit  (addr_hit)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int hit_cnt, wv_cnt, rs_cnt, tgt_drive_cnt;
    logic [7:0] wr_log [$];

    // Event monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (addr_hit) hit_cnt++;
        if (wr_valid) begin
            wv_cnt++;
            wr_log.push_back(wr_data);
        end
        if (rd_strobe) begin
            rs_cnt++;
            rd_idx++;
        end
        if (sda === 1'b0 && !m_sda_low) tgt_drive_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    // Inputs change 2 ns after the rising edge, away from DUT sampling.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        tick(1);
        hit_cnt = 0; wv_cnt = 0; rs_cnt = 0; tgt_drive_cnt = 0; rd_idx = 0;
        wr_log.delete();
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; tick(HALF - 2);
        scl = 1'b1; tick(HALF);
        m_sda_low = 1'b1; tick(HALF);
        scl = 1'b0; tick(2);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; tick(HALF - 2);
        scl = 1'b1; tick(HALF);
        m_sda_low = 1'b0; tick(HALF);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        m_sda_low = ~b; tick(HALF - 2);
        scl = 1'b1; tick(HALF);
        r = sda;
        scl = 1'b0; tick(2);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
        bus_bit(1'b1, r);
        acked = ~r;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            d[i] = r;
        end
        bus_bit(~ack, r);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(3);
        n_total++; if (sda !== 1'b1) $display("FAIL reset_sda: got %b want 1", sda); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", wr_data); else n_pass++;
        n_total++; if ({wr_valid, rd_strobe, addr_hit} !== 3'b000)
            $display("FAIL reset_pulses: got %b want 000", {wr_valid, rd_strobe, addr_hit}); else n_pass++;
        rst_n = 1'b1; tick(HALF);
    endtask

    task automatic test_read();
        logic ack; logic [7:0] d;
        clear_mon();
        rd_bytes[0] = 8'hA5;
        bus_start();
        send_byte({TGT, I2C_RW_READ}, ack);
        n_total++; if (ack !== 1'b1) $display("FAIL read_addr_ack: got %b want 1", ack); else n_pass++;
        recv_byte(1'b0, d);
        bus_stop();
        n_total++; if (d !== 8'hA5) $display("FAIL read_data: got %h want a5", d); else n_pass++;
        n_total++; if (hit_cnt !== 1) $display("FAIL read_addr_hit: got %0d want 1", hit_cnt); else n_pass++;
        n_total++; if (rs_cnt !== 1) $display("FAIL read_strobes: got %0d want 1", rs_cnt); else n_pass++;
    endtask

    task automatic test_write();
        logic ack;
        clear_mon();
        bus_start();
        send_byte({TGT, I2C_RW_WRITE}, ack);
        n_total++; if (ack !== 1'b1) $display("FAIL write_addr_ack: got %b want 1", ack); else n_pass++;
        send_byte(8'h3C, ack);
        n_total++; if (ack !== 1'b1) $display("FAIL write_data_ack: got %b want 1", ack); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL write_busy_mid: got %b want 1", busy); else n_pass++;
        bus_stop();
        n_total++; if (busy !== 1'b0) $display("FAIL write_busy_stop: got %b want 0", busy); else n_pass++;
        n_total++; if (wv_cnt !== 1) $display("FAIL write_valid_cnt: got %0d want 1", wv_cnt); else n_pass++;
        n_total++; if (wr_data !== 8'h3C) $display("FAIL write_data: got %h want 3c", wr_data); else n_pass++;
    endtask

    task automatic test_wrong_addr();
        logic ack, ack2;
        clear_mon();
        bus_start();
        send_byte({7'h11, I2C_RW_WRITE}, ack);
        send_byte(8'h00, ack2);
        n_total++; if (busy !== 1'b0) $display("FAIL miss_busy: got %b want 0", busy); else n_pass++;
        bus_stop();
        n_total++; if (ack !== 1'b0) $display("FAIL miss_addr_ack: got %b want 0", ack); else n_pass++;
        n_total++; if (ack2 !== 1'b0) $display("FAIL miss_data_ack: got %b want 0", ack2); else n_pass++;
        n_total++; if (hit_cnt !== 0 || wv_cnt !== 0)
            $display("FAIL miss_pulses: got hit %0d valid %0d want 0 0", hit_cnt, wv_cnt); else n_pass++;
        n_total++; if (tgt_drive_cnt !== 0) $display("FAIL miss_sda_driven: got %0d cycles want 0", tgt_drive_cnt); else n_pass++;
    endtask

    task automatic test_multi_read();
        logic ack, r; logic [7:0] d; int snap;
        clear_mon();
        rd_bytes[0] = 8'h01; rd_bytes[1] = 8'h02; rd_bytes[2] = 8'h03; rd_bytes[3] = 8'h00;
        bus_start();
        send_byte({TGT, I2C_RW_READ}, ack);
        for (int i = 0; i < 3; i++) begin
            recv_byte(i < 2, d);
            n_total++; if (d !== 8'(i + 1)) $display("FAIL multi_read_byte%0d: got %h want %h", i, d, 8'(i + 1)); else n_pass++;
        end
        n_total++; if (busy !== 1'b0) $display("FAIL multi_read_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (sda !== 1'b1) $display("FAIL multi_read_sda: got %b want 1", sda); else n_pass++;
        snap = tgt_drive_cnt;
        bus_bit(1'b1, r);
        n_total++; if (tgt_drive_cnt !== snap) $display("FAIL multi_read_ignore: got %0d drive cycles want %0d", tgt_drive_cnt, snap); else n_pass++;
        bus_stop();
        n_total++; if (rs_cnt !== 3) $display("FAIL multi_read_strobes: got %0d want 3", rs_cnt); else n_pass++;
    endtask

    task automatic test_rep_start();
        logic ack, r; logic [7:0] d;
        clear_mon();
        rd_bytes[0] = 8'($urandom_range(0, 255));
        bus_start();
        send_byte({TGT, I2C_RW_WRITE}, ack);
        for (int i = 0; i < 4; i++) bus_bit(i[0], r);
        bus_start();
        send_byte({TGT, I2C_RW_READ}, ack);
        n_total++; if (ack !== 1'b1) $display("FAIL rep_start_ack: got %b want 1", ack); else n_pass++;
        recv_byte(1'b0, d);
        bus_stop();
        n_total++; if (d !== rd_bytes[0]) $display("FAIL rep_start_data: got %h want %h", d, rd_bytes[0]); else n_pass++;
        n_total++; if (wv_cnt !== 0) $display("FAIL rep_start_no_valid: got %0d want 0", wv_cnt); else n_pass++;
        n_total++; if (hit_cnt !== 2) $display("FAIL rep_start_hits: got %0d want 2", hit_cnt); else n_pass++;
    endtask

    task automatic test_stop_mid();
        logic ack, r; logic [7:0] b;
        clear_mon();
        bus_start();
        send_byte({TGT, I2C_RW_WRITE}, ack);
        for (int i = 0; i < 4; i++) bus_bit(1'b0, r);
        bus_stop();
        n_total++; if (wv_cnt !== 0) $display("FAIL stop_mid_valid: got %0d want 0", wv_cnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL stop_mid_busy: got %b want 0", busy); else n_pass++;
        b = 8'($urandom_range(1, 255));
        bus_start();
        send_byte({TGT, I2C_RW_WRITE}, ack);
        send_byte(b, ack);
        bus_stop();
        n_total++; if (wv_cnt !== 1 || wr_data !== b)
            $display("FAIL stop_mid_recover: got %0d bytes data %h want 1 %h", wv_cnt, wr_data, b); else n_pass++;
    endtask

    task automatic test_reset_tx();
        logic ack; logic [7:0] b;
        clear_mon();
        rd_bytes[0] = 8'h00;
        bus_start();
        send_byte({TGT, I2C_RW_READ}, ack);
        m_sda_low = 1'b0; tick(HALF - 2);
        scl = 1'b1; tick(HALF / 2);
        n_total++; if (sda !== 1'b0 || busy !== 1'b1)
            $display("FAIL reset_tx_pre: got sda %b busy %b want 0 1", sda, busy); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (sda !== 1'b1) $display("FAIL reset_tx_sda: got %b want 1", sda); else n_pass++;
        n_total++; if ({busy, wr_valid, rd_strobe, addr_hit} !== 4'b0000 || wr_data !== 8'h00)
            $display("FAIL reset_tx_outputs: got %b data %h want 0000 00",
                     {busy, wr_valid, rd_strobe, addr_hit}, wr_data); else n_pass++;
        tick(4);
        rst_n = 1'b1; tick(HALF);
        clear_mon();
        b = 8'($urandom_range(1, 255));
        bus_start();
        send_byte({TGT, I2C_RW_WRITE}, ack);
        send_byte(b, ack);
        bus_stop();
        n_total++; if (wv_cnt !== 1 || wr_data !== b)
            $display("FAIL reset_tx_idle: got %0d bytes data %h want 1 %h", wv_cnt, wr_data, b); else n_pass++;
    endtask

    // Random transactions checked against a transaction-level expectation.
    task automatic test_random();
        logic [6:0] addr; logic rw, ack, hit; int nb; logic [7:0] d;
        logic [7:0] bytes [4];
        logic [7:0] exp_wr [$];
        for (int t = 0; t < 8; t++) begin
            clear_mon();
            addr = $urandom_range(0, 1) ? TGT : 7'($urandom_range(0, 127));
            rw   = 1'($urandom_range(0, 1));
            nb   = $urandom_range(1, 3);
            hit  = (addr == TGT);
            for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 4; i++) rd_bytes[i] = bytes[i];
            exp_wr.delete();
            if (hit && rw == I2C_RW_WRITE) for (int i = 0; i < nb; i++) exp_wr.push_back(bytes[i]);
            bus_start();
            send_byte({addr, rw}, ack);
            n_total++; if (ack !== hit) $display("FAIL rand%0d_addr_ack: got %b want %b", t, ack, hit); else n_pass++;
            if (rw == I2C_RW_WRITE) begin
                for (int i = 0; i < nb; i++) begin
                    send_byte(bytes[i], ack);
                    n_total++; if (ack !== hit) $display("FAIL rand%0d_wr_ack%0d: got %b want %b", t, i, ack, hit); else n_pass++;
                end
            end else if (hit) begin
                for (int i = 0; i < nb; i++) begin
                    recv_byte(i < nb - 1, d);
                    n_total++; if (d !== bytes[i]) $display("FAIL rand%0d_rd_byte%0d: got %h want %h", t, i, d, bytes[i]); else n_pass++;
                end
            end
            bus_stop();
            n_total++; if (wr_log.size() != exp_wr.size())
                $display("FAIL rand%0d_wr_count: got %0d want %0d", t, wr_log.size(), exp_wr.size());
            else if (wr_log != exp_wr) $display("FAIL rand%0d_wr_bytes: got %p want %p", t, wr_log, exp_wr);
            else n_pass++;
            n_total++; if (rs_cnt !== ((hit && rw == I2C_RW_READ) ? nb : 0))
                $display("FAIL rand%0d_strobes: got %0d want %0d", t, rs_cnt, (hit && rw) ? nb : 0); else n_pass++;
            n_total++; if (hit_cnt !== int'(hit) || busy !== 1'b0)
                $display("FAIL rand%0d_hit_busy: got %0d %b want %0d 0", t, hit_cnt, busy, hit); else n_pass++;
            if (!hit) begin
                n_total++; if (tgt_drive_cnt !== 0) $display("FAIL rand%0d_miss_drive: got %0d want 0", t, tgt_drive_cnt); else n_pass++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rd_bytes[i] = 8'h00;
        rd_idx = 0;
        test_reset();
        test_read();
        test_write();
        test_wrong_addr();
        test_multi_read();
        test_rep_start();
        test_stop_mid();
        test_reset_tx();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
